// File: rtl/systolic_feeder_pkg.sv
// systolic_feeder_pkg: shared FSM encoding, load-select codes and default sizing for the feeder
package systolic_feeder_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic LOAD_SEL_A = 1'b0;
  localparam logic LOAD_SEL_B = 1'b1;
  localparam int DEF_N = 4;
  localparam int DEF_W = 16;
endpackage

// File: rtl/systolic_feeder_lane.sv
// feeder_lane: N-word operand buffer for one array edge lane with a registered, windowed output
module feeder_lane #(
  parameter int N = 4,
  parameter int W = 16,
  parameter int L = 0,
  parameter int TW = 4,
  localparam int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr,
  input  logic [N*W-1:0] wr_data,
  input  logic           en,
  input  logic [TW-1:0]  step,
  output logic [W-1:0]   word
);
  logic [W-1:0] mem [N];
  logic [TW-1:0] d;
  logic hit;
  // step < L wraps d past N because the counter spans at least 3N values
  always_comb begin
    d = step - TW'(L);
    hit = en && d < TW'(N);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int k = 0; k < N; k++) mem[k] <= '0;
      word <= '0;
    end else begin
      if (wr) for (int k = 0; k < N; k++) mem[k] <= wr_data[k*W +: W];
      word <= hit ? mem[d[IW-1:0]] : '0;
    end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers A rows / B columns and drives the skewed wavefront into an N x N array
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W,
  localparam int IW = $clog2(N),
  localparam int TW = $clog2(3*N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_en,
  input  logic           load_sel,
  input  logic [IW-1:0]  load_idx,
  input  logic [N*W-1:0] load_data,
  output logic           load_ready,
  input  logic           start,
  output logic           busy,
  output logic           array_clr,
  output logic [N*W-1:0] west_out,
  output logic [N*W-1:0] north_out,
  output logic           done
);
  logic [2:0] state, nxt;
  logic [TW-1:0] cnt, step_next;
  logic feed_next;
  // cnt holds the step shown this cycle in FEED and keeps counting through DRAIN
  always_comb begin
    nxt = state == S_IDLE  ? (start ? S_CLEAR : S_IDLE) :
          state == S_CLEAR ? S_FEED :
          state == S_FEED  ? (cnt == TW'(2*N-2) ? S_DRAIN : S_FEED) :
          state == S_DRAIN ? (cnt == TW'(3*N-3) ? S_DONE : S_DRAIN) : S_IDLE;
    feed_next = nxt == S_FEED;
    step_next = state == S_CLEAR ? '0 : cnt + TW'(1);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      cnt <= '0;
      array_clr <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (state == S_FEED || state == S_DRAIN) ? cnt + TW'(1) : '0;
      array_clr <= nxt == S_CLEAR;
    end
  assign load_ready = state == S_IDLE;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  for (genvar i = 0; i < N; i++) begin : g_lane
    feeder_lane #(.N(N), .W(W), .L(i), .TW(TW)) u_row (
      .clk(clk), .rst(rst),
      .wr(load_ready && load_en && load_sel == LOAD_SEL_A && load_idx == IW'(i)),
      .wr_data(load_data), .en(feed_next), .step(step_next), .word(west_out[i*W +: W])
    );
    feeder_lane #(.N(N), .W(W), .L(i), .TW(TW)) u_col (
      .clk(clk), .rst(rst),
      .wr(load_ready && load_en && load_sel == LOAD_SEL_B && load_idx == IW'(i)),
      .wr_data(load_data), .en(feed_next), .step(step_next), .word(north_out[i*W +: W])
    );
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: scoreboard bench with a behavioural 4x4 PE array for end-to-end results
module tb_systolic_feeder;
  localparam int N = 4;
  localparam int W = 16;
  logic clk = 0, rst = 0, load_en = 0, load_sel = 0, start = 0;
  logic [1:0] load_idx = '0;
  logic [N*W-1:0] load_data = '0;
  logic load_ready, busy, array_clr, done;
  logic [N*W-1:0] west_out, north_out;
  int npass = 0, ntot = 0;

  always #5 clk = ~clk;

  systolic_feeder #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_sel(load_sel), .load_idx(load_idx),
    .load_data(load_data), .load_ready(load_ready), .start(start), .busy(busy),
    .array_clr(array_clr), .west_out(west_out), .north_out(north_out), .done(done)
  );

  typedef struct packed {
    logic clr, bsy, dn;
    logic [N*W-1:0] west, north;
  } exp_t;
  exp_t exp_q[$];
  logic [W-1:0] am [N][N];
  logic [W-1:0] bm [N][N];

  // output-stationary PE array: operands hop east/south, accumulator cleared by array_clr
  logic [31:0] acc [N][N];
  logic [W-1:0] wr [N][N];
  logic [W-1:0] nr [N][N];
  logic [W-1:0] wi [N][N];
  logic [W-1:0] ni [N][N];
  always_comb
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        wi[i][j] = j == 0 ? west_out[i*W +: W] : wr[i][(j == 0) ? 0 : j-1];
        ni[i][j] = i == 0 ? north_out[j*W +: W] : nr[(i == 0) ? 0 : i-1][j];
      end
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (array_clr) begin
          acc[i][j] <= '0;
          wr[i][j] <= '0;
          nr[i][j] <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + 32'(wi[i][j]) * 32'(ni[i][j]);
          wr[i][j] <= wi[i][j];
          nr[i][j] <= ni[i][j];
        end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic void push_run();
    exp_t e;
    int t;
    for (int c = 1; c <= 13; c++) begin
      e = '0;
      e.clr = c == 1;
      e.bsy = c <= 12;
      e.dn = c == 12;
      if (c >= 2 && c <= 8) begin
        t = c - 2;
        for (int i = 0; i < N; i++)
          if (t - i >= 0 && t - i < N) begin
            e.west[i*W +: W] = am[i][t-i];
            e.north[i*W +: W] = bm[t-i][i];
          end
      end
      exp_q.push_back(e);
    end
  endfunction

  task automatic load(input logic sel, input int idx, input logic [N*W-1:0] d);
    @(negedge clk);
    load_en = 1;
    load_sel = sel;
    load_idx = 2'(idx);
    load_data = d;
    @(negedge clk);
    load_en = 0;
  endtask

  task automatic load_all();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) d[k*W +: W] = am[i][k];
      load(1'b0, i, d);
    end
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) d[k*W +: W] = bm[k][j];
      load(1'b1, j, d);
    end
  endtask

  task automatic run(input int inj, input bit same_ld, input int scale, input int abort_c);
    exp_t e;
    @(negedge clk);
    start = 1;
    if (same_ld) begin
      load_en = 1;
      load_sel = 0;
      load_idx = 2;
      for (int k = 0; k < N; k++) begin
        load_data[k*W +: W] = 16'd7;
        am[2][k] = 16'd7;
      end
    end
    chk("accept_ready", 64'(load_ready), 64'd1);
    push_run();
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      start = 0;
      load_en = 0;
      if (c == abort_c) begin
        rst = 0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_clr", 64'(array_clr), 64'd0);
        chk("abort_west", west_out, 64'd0);
        chk("abort_north", north_out, 64'd0);
        chk("abort_ready", 64'(load_ready), 64'd1);
        exp_q.delete();
        return;
      end
      e = exp_q.pop_front();
      chk($sformatf("c%0d clr", c), 64'(array_clr), 64'(e.clr));
      chk($sformatf("c%0d busy", c), 64'(busy), 64'(e.bsy));
      chk($sformatf("c%0d done", c), 64'(done), 64'(e.dn));
      chk($sformatf("c%0d west", c), west_out, e.west);
      chk($sformatf("c%0d north", c), north_out, e.north);
      if (scale != 0 && c == 12)
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            chk($sformatf("pe%0d%0d", i, j), 64'(acc[i][j]), 64'(scale * (4*i + j + 1)));
      if (c == inj) begin
        load_en = 1;
        load_sel = 0;
        load_idx = 0;
        load_data = {N{16'h0005}};
        start = 1;
        chk("guard_ready", 64'(load_ready), 64'd0);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("after_busy", 64'(busy), 64'd0);
      chk("after_done", 64'(done), 64'd0);
    end
  endtask

  task automatic set_e2e(input int s);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        am[i][k] = (i == k) ? 16'(s) : 16'd0;
        bm[i][k] = 16'(4*i + k + 1);
      end
  endtask

  initial begin
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_clr", 64'(array_clr), 64'd0);
    chk("rst_west", west_out, 64'd0);
    chk("rst_north", north_out, 64'd0);
    chk("rst_ready", 64'(load_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        am[i][k] = 16'h0A00 + 16'(4*i + k);
        bm[i][k] = 16'h0B00 + 16'(4*i + k);
      end
    load_all();
    run(0, 0, 0, 0);
    set_e2e(1);
    load_all();
    run(0, 0, 1, 0);
    set_e2e(2);
    load_all();
    run(0, 0, 2, 0);
    run(6, 0, 2, 0);
    run(0, 0, 2, 0);
    run(0, 1, 0, 0);
    run(0, 0, 0, 7);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        am[i][k] = '0;
        bm[i][k] = '0;
      end
    run(0, 0, 0, 0);
    set_e2e(1);
    load_all();
    run(0, 0, 1, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
